operand_fetch: RTL and testbench

Issue stage between decode and execute. Holds one decoded instruction, checks its source and destination registers against the `regfile` lock vector, and reads operands through the `regfile` read ports. When the instruction is hazard-free it is latched with its operands into an output register toward execute, and the destination lock is set in the same cycle. It also provides a flush path and a saturating stall counter for performance monitoring.

---
 rtl/operand_fetch.sv | 138 +++++++++++++
 tb/tb_operand_fetch.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage: holds one decoded instruction, checks register locks,
// reads operands from the regfile and hands hazard-free instructions to execute.
package maverickOne_pkg;
  parameter int NUM_REGS = 32;
  parameter int XLEN     = 32;
endpackage

module operand_fetch #(
  parameter int NUM_REGS  = maverickOne_pkg::NUM_REGS,
  parameter int XLEN      = maverickOne_pkg::XLEN,
  parameter int PAYLOAD_W = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 id_valid_i,
  output logic                 id_ready_o,
  input  logic [AW-1:0]        id_rs1_addr_i,
  input  logic [AW-1:0]        id_rs2_addr_i,
  input  logic [AW-1:0]        id_rs3_addr_i,
  input  logic [AW-1:0]        id_rd_addr_i,
  input  logic [2:0]           id_uses_rs_i,
  input  logic                 id_writes_rd_i,
  input  logic [PAYLOAD_W-1:0] id_payload_i,
  output logic [AW-1:0]        rf_rs1_addr_o,
  output logic [AW-1:0]        rf_rs2_addr_o,
  output logic [AW-1:0]        rf_rs3_addr_o,
  input  logic [XLEN-1:0]      rf_rs1_data_i,
  input  logic [XLEN-1:0]      rf_rs2_data_i,
  input  logic [XLEN-1:0]      rf_rs3_data_i,
  input  logic [NUM_REGS-1:0]  rf_locks_i,
  output logic                 rf_lock_en_o,
  output logic [AW-1:0]        rf_lock_addr_o,
  output logic                 ex_valid_o,
  input  logic                 ex_ready_i,
  output logic [XLEN-1:0]      ex_rs1_data_o,
  output logic [XLEN-1:0]      ex_rs2_data_o,
  output logic [XLEN-1:0]      ex_rs3_data_o,
  output logic [AW-1:0]        ex_rd_addr_o,
  output logic                 ex_writes_rd_o,
  output logic [PAYLOAD_W-1:0] ex_payload_o,
  output logic [31:0]          stall_cnt_o
);

  logic                 h_valid;
  logic [AW-1:0]        h_rs [3];
  logic [AW-1:0]        h_rd;
  logic [2:0]           h_uses_rs;
  logic                 h_writes_rd;
  logic [PAYLOAD_W-1:0] h_payload;

  logic hazard;
  logic out_free;
  logic issue;
  logic accept;

  // x0 is hardwired, so it is excluded from both RAW and WAW checks
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (h_uses_rs[k] && (h_rs[k] != '0) && rf_locks_i[h_rs[k]]) hazard = 1'b1;
    end
    if (h_writes_rd && (h_rd != '0) && rf_locks_i[h_rd]) hazard = 1'b1;
    hazard = hazard && h_valid;
  end

  assign out_free   = !ex_valid_o || ex_ready_i;
  assign issue      = h_valid && !hazard && out_free && !flush_i && !rst_i;
  assign id_ready_o = !rst_i && !flush_i && (!h_valid || issue);
  assign accept     = id_valid_i && id_ready_o;

  assign rf_rs1_addr_o  = h_valid ? h_rs[0] : '0;
  assign rf_rs2_addr_o  = h_valid ? h_rs[1] : '0;
  assign rf_rs3_addr_o  = h_valid ? h_rs[2] : '0;
  assign rf_lock_en_o   = issue && h_writes_rd && (h_rd != '0);
  assign rf_lock_addr_o = h_rd;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_valid     <= 1'b0;
      h_rs[0]     <= '0;
      h_rs[1]     <= '0;
      h_rs[2]     <= '0;
      h_rd        <= '0;
      h_uses_rs   <= '0;
      h_writes_rd <= 1'b0;
      h_payload   <= '0;
    end else if (flush_i) begin
      h_valid <= 1'b0;
    end else if (accept) begin
      h_valid     <= 1'b1;
      h_rs[0]     <= id_rs1_addr_i;
      h_rs[1]     <= id_rs2_addr_i;
      h_rs[2]     <= id_rs3_addr_i;
      h_rd        <= id_rd_addr_i;
      h_uses_rs   <= id_uses_rs_i;
      h_writes_rd <= id_writes_rd_i;
      h_payload   <= id_payload_i;
    end else if (issue) begin
      h_valid <= 1'b0;
    end
  end

  // Output register only changes on issue, so it stays stable under backpressure
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_o     <= 1'b0;
      ex_rs1_data_o  <= '0;
      ex_rs2_data_o  <= '0;
      ex_rs3_data_o  <= '0;
      ex_rd_addr_o   <= '0;
      ex_writes_rd_o <= 1'b0;
      ex_payload_o   <= '0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (issue) begin
      ex_valid_o     <= 1'b1;
      ex_rs1_data_o  <= rf_rs1_data_i;
      ex_rs2_data_o  <= rf_rs2_data_i;
      ex_rs3_data_o  <= rf_rs3_data_i;
      ex_rd_addr_o   <= h_rd;
      ex_writes_rd_o <= h_writes_rd;
      ex_payload_o   <= h_payload;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (hazard && !flush_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a regfile environment plus a transaction-level
// model of the two issue slots, compared every cycle, with directed and random stimulus.
module tb_operand_fetch;
  localparam int NR = 32;
  localparam int XL = 32;
  localparam int AW = 5;
  localparam int PW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i, id_valid_i, id_ready_o, id_writes_rd_i;
  logic [AW-1:0] id_rs1_addr_i, id_rs2_addr_i, id_rs3_addr_i, id_rd_addr_i;
  logic [2:0]    id_uses_rs_i;
  logic [PW-1:0] id_payload_i;
  logic [AW-1:0] rf_rs1_addr_o, rf_rs2_addr_o, rf_rs3_addr_o, rf_lock_addr_o, ex_rd_addr_o;
  logic [XL-1:0] rf_rs1_data_i, rf_rs2_data_i, rf_rs3_data_i;
  logic [NR-1:0] rf_locks_i;
  logic          rf_lock_en_o, ex_valid_o, ex_ready_i, ex_writes_rd_o;
  logic [XL-1:0] ex_rs1_data_o, ex_rs2_data_o, ex_rs3_data_o;
  logic [PW-1:0] ex_payload_o;
  logic [31:0]   stall_cnt_o;

  operand_fetch #(.NUM_REGS(NR), .XLEN(XL), .PAYLOAD_W(PW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rs3_addr_i(id_rs3_addr_i),
    .id_rd_addr_i(id_rd_addr_i), .id_uses_rs_i(id_uses_rs_i), .id_writes_rd_i(id_writes_rd_i),
    .id_payload_i(id_payload_i),
    .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o), .rf_rs3_addr_o(rf_rs3_addr_o),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i), .rf_rs3_data_i(rf_rs3_data_i),
    .rf_locks_i(rf_locks_i), .rf_lock_en_o(rf_lock_en_o), .rf_lock_addr_o(rf_lock_addr_o),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_rs3_data_o(ex_rs3_data_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_writes_rd_o(ex_writes_rd_o), .ex_payload_o(ex_payload_o),
    .stall_cnt_o(stall_cnt_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0][AW-1:0] rs;
    logic [AW-1:0]      rd;
    logic [2:0]         uses;
    logic               wr;
    logic [PW-1:0]      pl;
  } instr_t;

  // Regfile environment: committed locks/contents plus this cycle's unlock write
  logic [NR-1:0] lk;
  logic [XL-1:0] mem [NR];
  logic          unl_en;
  logic [AW-1:0] unl_addr;
  logic [XL-1:0] unl_data;

  // Reference model: contents of the hold slot and the output slot
  instr_t        mH, mO;
  logic          mHv, mOv;
  logic [XL-1:0] mOd [3];
  logic [31:0]   mStall;
  logic          mHaz, mIssue, mIdReady, mLockEn;
  logic [XL-1:0] rdData [3];

  int            nChecks, nFails;
  bit            chkEn;
  logic [AW-1:0] lockLog [$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [AW-1:0] expAddr [3];
    for (int k = 0; k < 3; k++) expAddr[k] = mHv ? mH.rs[k] : '0;
    cmp("id_ready", 64'(id_ready_o), 64'(mIdReady));
    cmp("ex_valid", 64'(ex_valid_o), 64'(mOv));
    cmp("rf_rs1_addr", 64'(rf_rs1_addr_o), 64'(expAddr[0]));
    cmp("rf_rs2_addr", 64'(rf_rs2_addr_o), 64'(expAddr[1]));
    cmp("rf_rs3_addr", 64'(rf_rs3_addr_o), 64'(expAddr[2]));
    cmp("lock_en", 64'(rf_lock_en_o), 64'(mLockEn));
    if (mLockEn) cmp("lock_addr", 64'(rf_lock_addr_o), 64'(mH.rd));
    cmp("stall_cnt", 64'(stall_cnt_o), 64'(mStall));
    if (mOv) begin
      cmp("ex_rs1_data", 64'(ex_rs1_data_o), 64'(mOd[0]));
      cmp("ex_rs2_data", 64'(ex_rs2_data_o), 64'(mOd[1]));
      cmp("ex_rs3_data", 64'(ex_rs3_data_o), 64'(mOd[2]));
      cmp("ex_rd_addr", 64'(ex_rd_addr_o), 64'(mO.rd));
      cmp("ex_writes_rd", 64'(ex_writes_rd_o), 64'(mO.wr));
      cmp("ex_payload", 64'(ex_payload_o), 64'(mO.pl));
    end
  endtask

  // One clock cycle: present regfile view, check, then advance environment and model
  task automatic applyStimulus();
    logic [NR-1:0] lkView;
    logic [AW-1:0] a;
    instr_t        nextIn;
    lkView = lk;
    if (unl_en) lkView[unl_addr] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = mHv ? mH.rs[k] : '0;
      rdData[k] = (unl_en && a == unl_addr && a != '0) ? unl_data : mem[a];
    end
    rf_locks_i    = lkView;
    rf_rs1_data_i = rdData[0];
    rf_rs2_data_i = rdData[1];
    rf_rs3_data_i = rdData[2];
    #2;
    mHaz = 1'b0;
    if (mHv) begin
      for (int k = 0; k < 3; k++)
        if (mH.uses[k] && mH.rs[k] != '0 && lkView[mH.rs[k]]) mHaz = 1'b1;
      if (mH.wr && mH.rd != '0 && lkView[mH.rd]) mHaz = 1'b1;
    end
    mIssue   = mHv && !mHaz && (!mOv || ex_ready_i) && !flush_i && !rst_i;
    mIdReady = !rst_i && !flush_i && (!mHv || mIssue);
    mLockEn  = mIssue && mH.wr && mH.rd != '0;
    if (chkEn) checkOutput();
    if (rf_lock_en_o === 1'b1) lockLog.push_back(rf_lock_addr_o);
    nextIn = '{rs: {id_rs3_addr_i, id_rs2_addr_i, id_rs1_addr_i}, rd: id_rd_addr_i,
               uses: id_uses_rs_i, wr: id_writes_rd_i, pl: id_payload_i};
    @(posedge clk_i);
    if (unl_en && unl_addr != '0) begin
      mem[unl_addr] = unl_data;
      lk[unl_addr]  = 1'b0;
    end
    if (mLockEn) lk[mH.rd] = 1'b1;
    if (rst_i) begin
      mHv = 1'b0; mOv = 1'b0; mO = '0; mStall = '0;
      for (int k = 0; k < 3; k++) mOd[k] = '0;
    end else if (flush_i) begin
      mHv = 1'b0; mOv = 1'b0;
    end else begin
      if (mHv && mHaz && mStall != 32'hFFFF_FFFF) mStall = mStall + 1;
      if (mIssue) begin
        mO = mH; mOv = 1'b1;
        for (int k = 0; k < 3; k++) mOd[k] = rdData[k];
      end else if (ex_ready_i) begin
        mOv = 1'b0;
      end
      if (id_valid_i && mIdReady) begin
        mH = nextIn; mHv = 1'b1;
      end else if (mIssue) begin
        mHv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic setInstr(input int r1, input int r2, input int r3, input int rd,
                          input logic [2:0] uses, input logic wr, input logic [PW-1:0] pl);
    id_valid_i = 1'b1;
    id_rs1_addr_i = AW'(r1); id_rs2_addr_i = AW'(r2); id_rs3_addr_i = AW'(r3);
    id_rd_addr_i = AW'(rd); id_uses_rs_i = uses; id_writes_rd_i = wr; id_payload_i = pl;
  endtask

  task automatic idle();
    id_valid_i = 1'b0;
    unl_en = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic doReset();
    idle();
    ex_ready_i = 1'b1;
    rst_i = 1'b1;
    applyStimulus();
    rst_i = 1'b0;
    lk = '0;
    lockLog.delete();
  endtask

  task automatic randomizeInputs();
    int r;
    id_valid_i = ($urandom_range(0, 3) != 0);
    setInstr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
    id_valid_i = ($urandom_range(0, 3) != 0);
    ex_ready_i = ($urandom_range(0, 3) != 0);
    flush_i    = ($urandom_range(0, 49) == 0);
    rst_i      = ($urandom_range(0, 199) == 0);
    unl_en     = 1'b0;
    r = $urandom_range(1, 7);
    if ($urandom_range(0, 2) == 0 && lk[r]) begin
      unl_en = 1'b1; unl_addr = AW'(r); unl_data = $urandom;
    end
  endtask

  initial begin
    nChecks = 0; nFails = 0; chkEn = 0;
    lk = '0;
    for (int i = 0; i < NR; i++) mem[i] = (i == 0) ? '0 : XL'(i * 32'h1111);
    mHv = 1'b0; mOv = 1'b0; mH = '0; mO = '0; mStall = '0;
    for (int k = 0; k < 3; k++) mOd[k] = '0;
    unl_addr = '0; unl_data = '0;
    setInstr(0, 0, 0, 0, 3'b000, 1'b0, '0);
    #1;
    doReset();
    chkEn = 1;

    // Reset values while reset is held
    rst_i = 1'b1;
    applyStimulus();
    cmp("reset stall_cnt", 64'(stall_cnt_o), 64'd0);
    cmp("reset ex_valid", 64'(ex_valid_o), 64'd0);
    cmp("reset ex_rd_addr", 64'(ex_rd_addr_o), 64'd0);
    cmp("reset ex_rs1_data", 64'(ex_rs1_data_o), 64'd0);
    cmp("reset id_ready", 64'(id_ready_o), 64'd0);

    $display("[TB] independent stream");
    doReset();
    for (int i = 0; i < 4; i++) begin
      setInstr(i + 1, 0, 0, i + 5, 3'b001, 1'b1, PW'(i));
      applyStimulus();
    end
    idle();
    repeat (3) applyStimulus();
    cmp("stream lock count", 64'(lockLog.size()), 64'd4);
    for (int i = 0; i < 4 && i < lockLog.size(); i++)
      cmp("stream lock addr", 64'(lockLog[i]), 64'(i + 5));
    cmp("stream stall_cnt", 64'(stall_cnt_o), 64'd0);

    $display("[TB] RAW stall with unlock bypass");
    doReset();
    setInstr(0, 0, 0, 5, 3'b000, 1'b1, 32'hA);
    applyStimulus();
    setInstr(5, 0, 0, 6, 3'b001, 1'b0, 32'hB);
    applyStimulus();
    idle();
    repeat (3) applyStimulus();
    unl_en = 1'b1; unl_addr = 5'd5; unl_data = 32'hDEAD;
    applyStimulus();
    unl_en = 1'b0;
    cmp("raw ex_valid", 64'(ex_valid_o), 64'd1);
    cmp("raw bypass data", 64'(ex_rs1_data_o), 64'hDEAD);
    cmp("raw stall_cnt", 64'(stall_cnt_o), 64'd3);

    $display("[TB] WAW and x0");
    doReset();
    lk[9] = 1'b1;
    setInstr(0, 0, 0, 9, 3'b000, 1'b1, 32'h9);
    applyStimulus();
    idle();
    repeat (2) applyStimulus();
    unl_en = 1'b1; unl_addr = 5'd9; unl_data = 32'h99;
    applyStimulus();
    unl_en = 1'b0;
    cmp("waw stall_cnt", 64'(stall_cnt_o), 64'd2);
    cmp("waw ex_rd_addr", 64'(ex_rd_addr_o), 64'd9);
    cmp("waw relock", 64'(lk[9]), 64'd1);
    lockLog.delete();
    setInstr(0, 0, 0, 0, 3'b001, 1'b1, 32'h0);
    applyStimulus();
    idle();
    applyStimulus();
    cmp("x0 ex_valid", 64'(ex_valid_o), 64'd1);
    cmp("x0 ex_rd_addr", 64'(ex_rd_addr_o), 64'd0);
    cmp("x0 no lock", 64'(lockLog.size()), 64'd0);

    $display("[TB] execute backpressure");
    doReset();
    ex_ready_i = 1'b0;
    setInstr(1, 0, 0, 10, 3'b001, 1'b1, 32'h10);
    applyStimulus();
    setInstr(2, 0, 0, 11, 3'b001, 1'b1, 32'h11);
    applyStimulus();
    idle();
    repeat (3) applyStimulus();
    cmp("bp ex_valid", 64'(ex_valid_o), 64'd1);
    cmp("bp ex_rd_addr", 64'(ex_rd_addr_o), 64'd10);
    cmp("bp id_ready", 64'(id_ready_o), 64'd0);
    ex_ready_i = 1'b1;
    applyStimulus();
    cmp("bp second issue", 64'(ex_rd_addr_o), 64'd11);
    applyStimulus();
    cmp("bp stall_cnt", 64'(stall_cnt_o), 64'd0);

    $display("[TB] flush and reset");
    doReset();
    setInstr(3, 0, 0, 12, 3'b001, 1'b1, 32'h12);
    applyStimulus();
    idle();
    flush_i = 1'b1;
    applyStimulus();
    flush_i = 1'b0;
    cmp("flush ex_valid", 64'(ex_valid_o), 64'd0);
    cmp("flush h empty", 64'(rf_rs1_addr_o), 64'd0);
    cmp("flush no lock", 64'(lockLog.size()), 64'd0);
    doReset();
    lk[4] = 1'b1;
    setInstr(4, 0, 0, 13, 3'b001, 1'b1, 32'h13);
    applyStimulus();
    idle();
    repeat (4) applyStimulus();
    cmp("midstall stall_cnt", 64'(stall_cnt_o), 64'd4);
    rst_i = 1'b1;
    applyStimulus();
    cmp("rst stall_cnt", 64'(stall_cnt_o), 64'd0);
    cmp("rst ex_valid", 64'(ex_valid_o), 64'd0);
    cmp("rst id_ready", 64'(id_ready_o), 64'd0);
    cmp("rst lock_en", 64'(rf_lock_en_o), 64'd0);

    $display("[TB] random soak");
    doReset();
    repeat (20000) begin
      randomizeInputs();
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
